// File: rtl/fir_linia_if.sv
// Bus bundle between the FIR control FSM (master) and the sample delay line (slave).
interface fir_linia_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              FSM_reset_shift;
    logic              FSM_nowa_shift;
    logic [DATA_W-1:0] probka_in;
    logic [ADDR_W-1:0] adres_FIR;
    logic [DATA_W-1:0] shift_out;
    logic              shift_valid;
    logic [ADDR_W:0]   ile_w_linii;
    logic              linia_pelna;

    modport master (
        output FSM_reset_shift, FSM_nowa_shift, probka_in, adres_FIR,
        input  shift_out, shift_valid, ile_w_linii, linia_pelna
    );

    modport slave (
        input  FSM_reset_shift, FSM_nowa_shift, probka_in, adres_FIR,
        output shift_out, shift_valid, ile_w_linii, linia_pelna
    );
endinterface

// File: rtl/fir_linia_opozniajaca.sv
// FIR sample delay line with registered tap read and fill-level tracking.
// FIR_SHIFT_FORWARD_EN: a same-cycle read sees the post-push contents and fill level.
module fir_linia_opozniajaca #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    fir_linia_if.slave  bus
);
    typedef enum logic [1:0] {PUSTA, NAPELNIANIE, PELNA} stan_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] taps  [DEPTH];
    logic [DATA_W-1:0] widok [DEPTH];
    logic [ADDR_W:0]   ile, ile_next, ile_widok;
    stan_t             stan, stan_next;
    logic [DATA_W-1:0] odczyt, shift_out_r;
    logic              valid_next, shift_valid_r;
    logic              push;

    assign push = bus.FSM_nowa_shift && !bus.FSM_reset_shift;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin : fill_next
        ile_next  = ile;
        stan_next = stan;
        if (bus.FSM_reset_shift) begin
            ile_next  = '0;
            stan_next = PUSTA;
        end else if (bus.FSM_nowa_shift) begin
            if (ile != DEPTH_C) ile_next = ile + ONE_C;
            case (stan)
                PUSTA:       stan_next = NAPELNIANIE;
                NAPELNIANIE: if (ile == DEPTH_C - ONE_C) stan_next = PELNA;
                default:     stan_next = stan;
            endcase
        end
    end

    // Contents the read port sees this cycle: pre-push, or post-push when forwarding.
    always_comb begin : read_view
`ifdef FIR_SHIFT_FORWARD_EN
        widok[0] = push ? bus.probka_in : taps[0];
        for (int k = 1; k < DEPTH; k++) widok[k] = push ? taps[k-1] : taps[k];
        ile_widok = ile_next;
`else
        for (int k = 0; k < DEPTH; k++) widok[k] = taps[k];
        ile_widok = ile;
`endif
    end

    // Addresses with no matching tap (>= DEPTH) fall through to zero.
    always_comb begin : read_mux
        odczyt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (bus.adres_FIR == ADDR_W'(k)) odczyt = widok[k];
        end
        valid_next = ({1'b0, bus.adres_FIR} < ile_widok);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin : fill_reg
        if (rst) begin
            ile  <= '0;
            stan <= PUSTA;
        end else begin
            ile  <= ile_next;
            stan <= stan_next;
        end
    end

    // NOTE: the tap memory is reset because unwritten taps must read as zero for warm-up padding.
    always_ff @(posedge clk or posedge rst) begin : taps_reg
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
            shift_out_r   <= '0;
            shift_valid_r <= 1'b0;
        end else if (bus.FSM_reset_shift) begin
            for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
            shift_out_r   <= '0;
            shift_valid_r <= 1'b0;
        end else begin
            if (bus.FSM_nowa_shift) begin
                taps[0] <= bus.probka_in;
                for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
            end
            shift_out_r   <= odczyt;
            shift_valid_r <= valid_next;
        end
    end

    assign bus.shift_out   = shift_out_r;
    assign bus.shift_valid = shift_valid_r;
    assign bus.ile_w_linii = ile;
    assign bus.linia_pelna = (stan == PELNA);
endmodule

// File: tb/tb_fir_linia_opozniajaca.sv
// Bench for the delay line: queue-based reference model, directed and random stimulus,
// a DEPTH=32 instance and a DEPTH=5 instance.
module tb_fir_linia_opozniajaca;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] q  [$];
    logic [15:0] q5 [$];

    fir_linia_if #(.DATA_W(16), .ADDR_W(5)) bus ();
    fir_linia_if #(.DATA_W(16), .ADDR_W(3)) bus5 ();

    fir_linia_opozniajaca #(.DATA_W(16), .DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    fir_linia_opozniajaca #(.DATA_W(16), .DEPTH(5), .ADDR_W(3)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the 32-deep line, checked against the queue model (front = newest).
    task automatic step(input bit rs, input bit push, input logic [15:0] smp, input logic [4:0] a);
        logic [15:0] view [$];
        logic [15:0] exp_out;
        bit          exp_v;
        bus.FSM_reset_shift = rs;
        bus.FSM_nowa_shift  = push;
        bus.probka_in       = smp;
        bus.adres_FIR       = a;
        view = q;
        if (rs) q.delete();
        else if (push) begin
            q.push_front(smp);
            if (q.size() > 32) void'(q.pop_back());
        end
`ifdef FIR_SHIFT_FORWARD_EN
        view = q;
`endif
        exp_v   = !rs && (int'(a) < view.size());
        exp_out = exp_v ? view[a] : 16'h0000;
        @(posedge clk);
        #1;
        check("shift_out",   {16'h0, bus.shift_out}, {16'h0, exp_out});
        check("shift_valid", {31'h0, bus.shift_valid}, {31'h0, exp_v});
        check("ile_w_linii", {26'h0, bus.ile_w_linii}, q.size());
        check("linia_pelna", {31'h0, bus.linia_pelna}, {31'h0, q.size() == 32});
    endtask

    task automatic step5(input bit push, input logic [15:0] smp, input logic [2:0] a);
        logic [15:0] view [$];
        logic [15:0] exp_out;
        bit          exp_v;
        bus5.FSM_reset_shift = 1'b0;
        bus5.FSM_nowa_shift  = push;
        bus5.probka_in       = smp;
        bus5.adres_FIR       = a;
        view = q5;
        if (push) begin
            q5.push_front(smp);
            if (q5.size() > 5) void'(q5.pop_back());
        end
`ifdef FIR_SHIFT_FORWARD_EN
        view = q5;
`endif
        exp_v   = int'(a) < view.size();
        exp_out = exp_v ? view[a] : 16'h0000;
        @(posedge clk);
        #1;
        check("d5_shift_out",   {16'h0, bus5.shift_out}, {16'h0, exp_out});
        check("d5_shift_valid", {31'h0, bus5.shift_valid}, {31'h0, exp_v});
        check("d5_ile_w_linii", {28'h0, bus5.ile_w_linii}, q5.size());
        check("d5_linia_pelna", {31'h0, bus5.linia_pelna}, {31'h0, q5.size() == 5});
    endtask

    initial begin
        logic [15:0] t2_out [4];
        bit          t2_v   [4];
        t2_out = '{16'h2000, 16'hC000, 16'h4000, 16'h0000};
        t2_v   = '{1'b1, 1'b1, 1'b1, 1'b0};

        bus.FSM_reset_shift  = 1'b0; bus.FSM_nowa_shift  = 1'b0;
        bus.probka_in        = '0;   bus.adres_FIR       = '0;
        bus5.FSM_reset_shift = 1'b0; bus5.FSM_nowa_shift = 1'b0;
        bus5.probka_in       = '0;   bus5.adres_FIR      = '0;

        // Power-on reset.
        #1 rst = 1'b1;
        #1;
        check("por_shift_out",   {16'h0, bus.shift_out}, 32'h0);
        check("por_shift_valid", {31'h0, bus.shift_valid}, 32'h0);
        check("por_ile",         {26'h0, bus.ile_w_linii}, 32'h0);
        check("por_pelna",       {31'h0, bus.linia_pelna}, 32'h0);
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // Fill with three samples, then read taps 0..3.
        step(0, 1, 16'h4000, 5'd0);
        step(0, 1, 16'hC000, 5'd0);
        step(0, 1, 16'h2000, 5'd0);
        check("t2_ile", {26'h0, bus.ile_w_linii}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 16'h0, 5'(i));
            check("t2_out",   {16'h0, bus.shift_out}, {16'h0, t2_out[i]});
            check("t2_valid", {31'h0, bus.shift_valid}, {31'h0, t2_v[i]});
        end

        // Same-cycle push and read at tap 0.
        step(0, 1, 16'h4000, 5'd0);
        step(0, 1, 16'h2000, 5'd0);
`ifdef FIR_SHIFT_FORWARD_EN
        check("t5_forward", {16'h0, bus.shift_out}, 32'h2000);
`else
        check("t5_forward", {16'h0, bus.shift_out}, 32'h4000);
`endif

        // Saturation: 40 pushes of value 1..40.
        step(1, 0, 16'h0, 5'd0);
        for (int i = 1; i <= 40; i++) step(0, 1, 16'(i), 5'd0);
        check("t3_ile",   {26'h0, bus.ile_w_linii}, 32'd32);
        check("t3_pelna", {31'h0, bus.linia_pelna}, 32'd1);
        step(0, 0, 16'h0, 5'd0);
        check("t3_a0", {16'h0, bus.shift_out}, 32'd40);
        step(0, 0, 16'h0, 5'd31);
        check("t3_a31", {16'h0, bus.shift_out}, 32'd9);

        // Clear wins over a simultaneous push.
        step(1, 1, 16'h1234, 5'd0);
        check("t4_ile", {26'h0, bus.ile_w_linii}, 32'd0);
        step(0, 0, 16'h0, 5'd0);
        check("t4_a0", {16'h0, bus.shift_out}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 25) == 0, ($urandom % 4) != 0, 16'($urandom), 5'($urandom));
        end

        // Asynchronous reset with the line full.
        for (int i = 0; i < 34; i++) step(0, 1, 16'($urandom | 1), 5'($urandom));
        check("t1_full", {31'h0, bus.linia_pelna}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_shift_out",   {16'h0, bus.shift_out}, 32'h0);
        check("t1_shift_valid", {31'h0, bus.shift_valid}, 32'h0);
        check("t1_ile",         {26'h0, bus.ile_w_linii}, 32'h0);
        check("t1_pelna",       {31'h0, bus.linia_pelna}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        q5.delete();
        for (int i = 0; i < 32; i++) step(0, 0, 16'hFFFF, 5'(i));

        // DEPTH=5: out-of-range addresses, then six pushes drop the first sample.
        for (int i = 5; i < 8; i++) begin
            step5(0, 16'h0, 3'(i));
            check("t6_oor_out",   {16'h0, bus5.shift_out}, 32'h0);
            check("t6_oor_valid", {31'h0, bus5.shift_valid}, 32'h0);
        end
        for (int i = 1; i <= 6; i++) step5(1, 16'(i * 16'h0101), 3'($urandom));
        for (int i = 0; i < 8; i++) step5(0, 16'h0, 3'(i));
        step5(0, 16'h0, 3'd4);
        check("t6_oldest", {16'h0, bus5.shift_out}, 32'h0202);
        step5(0, 16'h0, 3'd7);
        check("t6_oor_full", {31'h0, bus5.shift_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
